// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1RW SRAM port (two 8-bit macros) between the CPU and the WB loader.
// Grants one requester, pulses the active-low chip select for one cycle, waits out read latency, then acks.
module sram_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              wb_req,
  input  logic              wb_we,
  input  logic [1:0]        wb_sel,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_ack,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [1:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(RD_WAIT - 1);

  state_t            state_r;
  logic              owner_wb_r;
  logic              last_wb_r;
  logic              we_r;
  logic [1:0]        wait_cnt_r;

  logic              pick_wb_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [1:0]        sel_mask_s;

  // Round-robin choice and mux of the winning requester's command.
  always_comb begin
    pick_wb_s   = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_mask_s  = 2'b00;
    if (cpu_req && wb_req) begin
      pick_wb_s = ~last_wb_r;
    end else if (wb_req) begin
      pick_wb_s = 1'b1;
    end else begin
      pick_wb_s = 1'b0;
    end
    if (pick_wb_s) begin
      sel_we_s    = wb_we;
      sel_addr_s  = wb_addr;
      sel_wdata_s = wb_wdata;
      sel_mask_s  = wb_we ? wb_sel : 2'b00;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
      sel_mask_s  = cpu_we ? 2'b11 : 2'b00;
    end
  end

  // Access sequencer: all SRAM strobes, acks and read data are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      owner_wb_r <= 1'b0;
      last_wb_r  <= 1'b1;
      we_r       <= 1'b0;
      wait_cnt_r <= 2'b00;
      mem_csb    <= 1'b1;
      mem_web    <= 1'b1;
      mem_wmask  <= 2'b00;
      mem_addr   <= '0;
      mem_din    <= '0;
      cpu_ack    <= 1'b0;
      wb_ack     <= 1'b0;
      cpu_rdata  <= '0;
      wb_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cpu_req || wb_req) begin
            owner_wb_r <= pick_wb_s;
            we_r       <= sel_we_s;
            mem_csb    <= 1'b0;
            mem_web    <= ~sel_we_s;
            mem_addr   <= sel_addr_s;
            mem_din    <= sel_wdata_s;
            mem_wmask  <= sel_mask_s;
            busy       <= 1'b1;
            state_r    <= S_ISSUE;
          end else begin
            state_r    <= S_IDLE;
          end
        end
        S_ISSUE: begin
          mem_csb <= 1'b1;
          mem_web <= 1'b1;
          if (we_r) begin
            cpu_ack <= ~owner_wb_r;
            wb_ack  <= owner_wb_r;
            state_r <= S_RESP;
          end else begin
            wait_cnt_r <= WAIT_LOAD;
            state_r    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_r == 2'b00) begin
            if (owner_wb_r) begin
              wb_rdata <= mem_dout;
            end else begin
              cpu_rdata <= mem_dout;
            end
            cpu_ack <= ~owner_wb_r;
            wb_ack  <= owner_wb_r;
            state_r <= S_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
          end
        end
        S_RESP: begin
          cpu_ack   <= 1'b0;
          wb_ack    <= 1'b0;
          last_wb_r <= owner_wb_r;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          mem_csb <= 1'b1;
          mem_web <= 1'b1;
          cpu_ack <= 1'b0;
          wb_ack  <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
